// File: rtl/sdu_rx.sv
// ADC capture window for SDUltrasound: trigger, skip a delay, store a window in block RAM, read back.
// Optional coherent averaging over 2**AVG_LOG2 passes is enabled by defining SDU_RX_AVG_EN.
module sdu_rx #(
  parameter int AW       = 12,
  parameter int AVG_LOG2 = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          sdu_rx_en,
  input  logic          sdu_trig,
  input  logic [15:0]   sdu_delay,
  input  logic [AW:0]   sdu_len,
  input  logic [15:0]   adc_in,
  input  logic          adc_strobe,
  input  logic          sdu_rd_strobe,
  output logic [15:0]   sdu_rd_data,
  output logic          sdu_rd_valid,
  output logic          sdu_seq_done_strobe,
  output logic          sdu_rx_busy,
  output logic          sdu_trig_lost
);

  localparam int DEPTH = 2 ** AW;
  localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [AW:0] DEPTH_W = {1'b1, {AW{1'b0}}};

`ifdef SDU_RX_AVG_EN
  localparam int RW     = 16 + AVG_LOG2;
  localparam int RD_LSB = AVG_LOG2;
  localparam logic [PW-1:0] LAST_PASS = {PW{1'b1}};
`else
  localparam int RW     = 16;
  localparam int RD_LSB = 0;
  localparam logic [PW-1:0] LAST_PASS = {PW{1'b0}};
`endif

  typedef enum logic [2:0] {IDLE, ARMED, DELAY, CAPTURE, DONE} state_t;

  state_t state, state_nxt;

  logic [15:0]   delay_q;
  logic [15:0]   delay_cnt;
  logic [AW:0]   len_q;
  logic [AW:0]   wr_cnt;
  logic [AW-1:0] rd_idx;
  logic [PW-1:0] pass_cnt;

  logic          start, capture_wr, finish, done_set, pass_adv, rd_fire, lost_set;
  logic          relatch;
  logic [15:0]   start_delay;
  logic [AW:0]   start_len;
  logic [AW:0]   len_clamp;

  logic [RW-1:0] ram [DEPTH];

  // Length and delay are only taken from the inputs at the first pass of a run.
  assign relatch     = (pass_cnt == '0);
  assign len_clamp   = (sdu_len > DEPTH_W) ? DEPTH_W : sdu_len;
  assign start_delay = relatch ? sdu_delay : delay_q;
  assign start_len   = relatch ? len_clamp : len_q;
  assign sdu_rx_busy = (state == DELAY) || (state == CAPTURE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    capture_wr = 1'b0;
    finish     = 1'b0;
    done_set   = 1'b0;
    pass_adv   = 1'b0;
    rd_fire    = 1'b0;
    lost_set   = 1'b0;
    if (!sdu_rx_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = ARMED;
        ARMED, DONE: begin
          if (sdu_trig) begin
            start = 1'b1;
            if (start_delay != 16'd0)  state_nxt = DELAY;
            else if (start_len == '0)  finish    = 1'b1;
            else                       state_nxt = CAPTURE;
          end else if ((state == DONE) && sdu_rd_strobe && (len_q != '0)) begin
            rd_fire = 1'b1;
          end
        end
        DELAY: begin
          lost_set = sdu_trig;
          if (adc_strobe && (delay_cnt == 16'd1)) begin
            if (len_q == '0) finish    = 1'b1;
            else             state_nxt = CAPTURE;
          end
        end
        CAPTURE: begin
          lost_set = sdu_trig;
          if (adc_strobe) begin
            capture_wr = 1'b1;
            if ((wr_cnt + (AW+1)'(1)) == len_q) finish = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (finish) begin
        done_set = 1'b1;
        if (pass_cnt == LAST_PASS) begin
          state_nxt = DONE;
        end else begin
          state_nxt = ARMED;
          pass_adv  = 1'b1;
        end
      end
    end
  end

  // Control registers; the pass counter returns to zero once a run reaches DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      delay_q             <= '0;
      delay_cnt           <= '0;
      len_q               <= '0;
      wr_cnt              <= '0;
      rd_idx              <= '0;
      pass_cnt            <= '0;
      sdu_trig_lost       <= 1'b0;
      sdu_seq_done_strobe <= 1'b0;
      sdu_rd_valid        <= 1'b0;
    end else begin
      sdu_seq_done_strobe <= done_set;
      sdu_rd_valid        <= rd_fire;
      if (state_nxt == IDLE) begin
        wr_cnt        <= '0;
        rd_idx        <= '0;
        pass_cnt      <= '0;
        sdu_trig_lost <= 1'b0;
      end else begin
        if (lost_set) sdu_trig_lost <= 1'b1;
        if (start) begin
          if (relatch) begin
            delay_q <= sdu_delay;
            len_q   <= len_clamp;
          end
          delay_cnt <= start_delay;
          wr_cnt    <= '0;
          rd_idx    <= '0;
        end
        if ((state == DELAY) && adc_strobe) delay_cnt <= delay_cnt - 16'd1;
        if (capture_wr) wr_cnt <= wr_cnt + (AW+1)'(1);
        if (done_set) pass_cnt <= pass_adv ? (pass_cnt + PW'(1)) : '0;
        if (rd_fire) begin
          if ({1'b0, rd_idx} == (len_q - (AW+1)'(1))) rd_idx <= '0;
          else                                         rd_idx <= rd_idx + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     sdu_rd_data <= '0;
    else if (rd_fire) sdu_rd_data <= ram[rd_idx][RD_LSB +: 16];
  end

`ifdef SDU_RX_AVG_EN
  logic          wr_pend;
  logic          first_d;
  logic [AW-1:0] wr_addr_d;
  logic [15:0]   sample_d;
  logic [RW-1:0] sample_x;
  logic [RW-1:0] acc_q;

  assign sample_x = {{AVG_LOG2{sample_d[15]}}, sample_d};

  // Read-modify-write: old sum is read on the strobe, the new sum lands one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_pend   <= 1'b0;
      first_d   <= 1'b0;
      wr_addr_d <= '0;
      sample_d  <= '0;
    end else begin
      wr_pend <= capture_wr;
      if (capture_wr) begin
        first_d   <= (pass_cnt == '0);
        wr_addr_d <= wr_cnt[AW-1:0];
        sample_d  <= adc_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture_wr) acc_q <= ram[wr_cnt[AW-1:0]];
    if (wr_pend)    ram[wr_addr_d] <= first_d ? sample_x : (acc_q + sample_x);
  end
`else
  always_ff @(posedge clk) begin
    if (capture_wr) ram[wr_cnt[AW-1:0]] <= adc_in;
  end
`endif

endmodule
